// File: rtl/bell_round_if.sv
// Handshake/bus bundle between the keypad/bell decoder side and bell_round_ctrl.
// master drives cards, pot and bell levels; slave (the controller) drives grant, verdict and scores.
interface bell_round_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 8
);
   logic                           round_start;
   logic [1:0]                     c1;
   logic [1:0]                     c2;
   logic [2:0]                     n1;
   logic [2:0]                     n2;
   logic [7:0]                     pot;
   logic [NUM_PLAYERS-1:0]         bell;
   logic [NUM_PLAYERS-1:0]         grant;
   logic                           verdict_valid;
   logic                           verdict_right;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores;
   logic [NUM_PLAYERS-1:0]         winner;
   logic                           game_over;

   modport master (
      output round_start, c1, c2, n1, n2, pot, bell,
      input  grant, verdict_valid, verdict_right, scores, winner, game_over
   );

   modport slave (
      input  round_start, c1, c2, n1, n2, pot, bell,
      output grant, verdict_valid, verdict_right, scores, winner, game_over
   );
endinterface

// File: rtl/bell_round_ctrl.sv
// Bell card game round controller: latches cards, arbitrates bells, judges, keeps saturating scores, detects a winner.
// Define BELL_RR_TIE_EN for round-robin tie resolution; otherwise fixed priority (lowest index wins).
//
// state    | meaning
// IDLE     | waiting for round_start, bells ignored
// ARMED    | cards latched, waiting for a bell (round_start re-latches)
// JUDGE    | verdict and new scores registered, verdict_valid pulses
// CHECK    | winner/game_over registered
// WAIT_REL | grant held until every bell is released
// OVER     | game finished, everything frozen until reset
module bell_round_ctrl #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 8,
   parameter int TARGET_SUM  = 5,
   parameter int WIN_MARGIN  = 50,
   parameter int PENALTY     = 1
) (
   input logic        clk,
   input logic        rst,
   bell_round_if.slave bus
);
   localparam int SW = SCORE_W;
   localparam int WW = SCORE_W + 2;
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam logic signed [WW-1:0] S_MAX    = WW'(2 ** (SW - 1) - 1);
   localparam logic signed [WW-1:0] S_MIN    = ~S_MAX;
   localparam logic signed [WW-1:0] PEN_W    = WW'(PENALTY);
   localparam logic signed [WW-1:0] MARGIN_W = WW'(WIN_MARGIN);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_JUDGE, S_CHECK, S_WAIT_REL, S_OVER
   } state_t;

   state_t                   state;
   logic [1:0]               c1_q, c2_q;
   logic [2:0]               n1_q, n2_q;
   logic [NUM_PLAYERS-1:0]   grant_q;
   logic [NUM_PLAYERS-1:0]   winner_q;
   logic                     vv_q, vr_q, go_q;
   logic signed [SW-1:0]     score_q  [NUM_PLAYERS];
   logic signed [SW-1:0]     score_nx [NUM_PLAYERS];
   logic [NUM_PLAYERS*SW-1:0] scores_p;

   logic                     right_c;
   logic [NUM_PLAYERS-1:0]   win_c;
   logic [NUM_PLAYERS-1:0]   bell_rot;
   logic [PW:0]              base;
   logic [PW:0]              off;
   logic [PW:0]              sum;
   logic [PW-1:0]            pick_idx;
   logic signed [WW-1:0]     pot_w;
   logic signed [WW-1:0]     wide;

   function automatic logic signed [WW-1:0] ext(input logic signed [SW-1:0] v);
      return {{2{v[SW-1]}}, v};
   endfunction

`ifdef BELL_RR_TIE_EN
   logic [PW-1:0]            rr_ptr;
   logic [2*NUM_PLAYERS-1:0] bell_dbl;

   // Rotate the bell vector so the search begins at the pointer.
   assign bell_dbl = {bus.bell, bus.bell};
   assign bell_rot = bell_dbl[{1'b0, rr_ptr} +: NUM_PLAYERS];
   assign base     = {1'b0, rr_ptr};
`else
   assign bell_rot = bus.bell;
   assign base     = '0;
`endif

   always_comb begin
      off = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (bell_rot[i]) off = (PW + 1)'(i);
      end
      sum = base + off;
      if (sum >= (PW + 1)'(NUM_PLAYERS)) sum = sum - (PW + 1)'(NUM_PLAYERS);
      pick_idx = PW'(sum);
   end

   always_comb begin
      right_c = 1'b0;
      if (c1_q == c2_q) right_c = (({1'b0, n1_q} + {1'b0, n2_q}) == 4'(TARGET_SUM));
      else              right_c = (n1_q == 3'(TARGET_SUM)) || (n2_q == 3'(TARGET_SUM));
   end

   assign pot_w = WW'(bus.pot);

   always_comb begin
      wide = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         wide = ext(score_q[i]);
         if (grant_q[i])    wide = right_c ? wide + pot_w : wide - PEN_W;
         else if (!right_c) wide = wide + PEN_W;
         if (wide > S_MAX)      score_nx[i] = S_MAX[SW-1:0];
         else if (wide < S_MIN) score_nx[i] = S_MIN[SW-1:0];
         else                   score_nx[i] = wide[SW-1:0];
      end
   end

   // Margin compare is widened so score + WIN_MARGIN never wraps.
   always_comb begin
      win_c = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         win_c[i] = 1'b1;
         for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (j != i && !(ext(score_q[i]) > ext(score_q[j]) + MARGIN_W)) win_c[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         c1_q     <= '0;
         c2_q     <= '0;
         n1_q     <= '0;
         n2_q     <= '0;
         grant_q  <= '0;
         winner_q <= '0;
         vv_q     <= 1'b0;
         vr_q     <= 1'b0;
         go_q     <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
`ifdef BELL_RR_TIE_EN
         rr_ptr   <= '0;
`endif
      end else begin
         vv_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.round_start) begin
                  c1_q  <= bus.c1;
                  c2_q  <= bus.c2;
                  n1_q  <= bus.n1;
                  n2_q  <= bus.n2;
                  state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (|bus.bell) begin
                  grant_q <= NUM_PLAYERS'(1) << pick_idx;
                  state   <= S_JUDGE;
`ifdef BELL_RR_TIE_EN
                  rr_ptr  <= (pick_idx == PW'(NUM_PLAYERS - 1)) ? '0 : pick_idx + 1'b1;
`endif
               end else if (bus.round_start) begin
                  c1_q <= bus.c1;
                  c2_q <= bus.c2;
                  n1_q <= bus.n1;
                  n2_q <= bus.n2;
               end
            end
            S_JUDGE: begin
               vv_q  <= 1'b1;
               vr_q  <= right_c;
               for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= score_nx[i];
               state <= S_CHECK;
            end
            S_CHECK: begin
               winner_q <= win_c;
               go_q     <= |win_c;
               if (|win_c) begin
                  grant_q <= '0;
                  state   <= S_OVER;
               end else begin
                  state   <= S_WAIT_REL;
               end
            end
            S_WAIT_REL: begin
               if (bus.bell == '0) begin
                  grant_q <= '0;
                  state   <= S_IDLE;
               end
            end
            S_OVER: begin
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      scores_p = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) scores_p[i*SW +: SW] = score_q[i];
   end

   assign bus.grant         = grant_q;
   assign bus.verdict_valid = vv_q;
   assign bus.verdict_right = vr_q;
   assign bus.scores        = scores_p;
   assign bus.winner        = winner_q;
   assign bus.game_over     = go_q;
endmodule

// File: tb/tb_bell_round_ctrl.sv
// Scoreboard bench for bell_round_ctrl: directed rounds from the test plan plus random rounds
// checked against a plain-integer model of the game rules.
module tb_bell_round_ctrl;
   localparam int NP     = 2;
   localparam int SW     = 8;
   localparam int TS     = 5;
   localparam int MARGIN = 50;
   localparam int PEN    = 1;
   localparam int SMAX   = 2 ** (SW - 1) - 1;
   localparam int SMIN   = -(2 ** (SW - 1));

   typedef struct packed {
      logic [NP-1:0]    g;
      logic             right;
      logic [NP*SW-1:0] sc;
      logic [NP-1:0]    win;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bell_round_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) bus ();

   bell_round_ctrl #(
      .NUM_PLAYERS(NP), .SCORE_W(SW), .TARGET_SUM(TS), .WIN_MARGIN(MARGIN), .PENALTY(PEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t pend;
   bit   pend_v = 1'b0;

   int ms [NP];
   int rr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   function automatic logic [NP*SW-1:0] model_scores();
      logic [NP*SW-1:0] s;
      s = '0;
      for (int i = 0; i < NP; i++) s[i*SW +: SW] = SW'(ms[i]);
      return s;
   endfunction

   function automatic logic [NP-1:0] model_winner();
      logic [NP-1:0] w;
      w = '0;
      for (int i = 0; i < NP; i++) begin
         bit lead = 1'b1;
         for (int j = 0; j < NP; j++)
            if (j != i && !(ms[i] > ms[j] + MARGIN)) lead = 1'b0;
         w[i] = lead;
      end
      return w;
   endfunction

   // Game rules as plain integer arithmetic: who pressed first in search order, right/wrong, transfer, clamp.
   function automatic exp_t model_press(input int a1, input int a2, input int b1, input int b2,
                                        input int p, input logic [NP-1:0] bl);
      exp_t e;
      int   g = -1;
      bit   right;
      for (int k = 0; k < NP; k++) begin
         int idx = (rr + k) % NP;
         if (g < 0 && ((int'(bl) >> idx) & 1) == 1) g = idx;
      end
`ifdef BELL_RR_TIE_EN
      rr = (g + 1) % NP;
`endif
      right = (a1 == a2) ? (b1 + b2 == TS) : (b1 == TS || b2 == TS);
      for (int i = 0; i < NP; i++) begin
         if (i == g)      ms[i] += right ? p : -PEN;
         else if (!right) ms[i] += PEN;
         if (ms[i] > SMAX) ms[i] = SMAX;
         if (ms[i] < SMIN) ms[i] = SMIN;
      end
      e.g     = NP'(1) << g;
      e.right = right;
      e.sc    = model_scores();
      e.win   = model_winner();
      return e;
   endfunction

   always @(negedge clk) begin
      if (pend_v) begin
         check("winner", bus.winner, pend.win);
         check("game_over", bus.game_over, |pend.win);
         pend_v = 1'b0;
      end
      if (rst && bus.verdict_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_verdict", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("verdict_right", bus.verdict_right, mon_e.right);
            check("scores", bus.scores, mon_e.sc);
            check("grant_at_verdict", bus.grant, mon_e.g);
            pend   = mon_e;
            pend_v = 1'b1;
         end
      end
   end

   task automatic garbage_cards();
      bus.c1 = 2'($urandom);
      bus.c2 = 2'($urandom);
      bus.n1 = 3'($urandom);
      bus.n2 = 3'($urandom);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst             = 1'b0;
      bus.round_start = 1'b0;
      bus.bell        = '0;
      bus.pot         = '0;
      repeat (2) @(negedge clk);
      check("rst_grant", bus.grant, 0);
      check("rst_verdict_valid", bus.verdict_valid, 0);
      check("rst_verdict_right", bus.verdict_right, 0);
      check("rst_scores", bus.scores, 0);
      check("rst_winner", bus.winner, 0);
      check("rst_game_over", bus.game_over, 0);
      rst = 1'b1;
      for (int i = 0; i < NP; i++) ms[i] = 0;
      rr = 0;
   endtask

   task automatic do_round(input int a1, input int a2, input int b1, input int b2, input int p,
                           input logic [NP-1:0] bl, input int hold, input bit relatch, input bit collide);
      exp_t e;
      @(negedge clk);
      bus.round_start = 1'b1;
      if (relatch) begin
         garbage_cards();
         @(negedge clk);
      end
      bus.c1  = 2'(a1);
      bus.c2  = 2'(a2);
      bus.n1  = 3'(b1);
      bus.n2  = 3'(b2);
      bus.pot = 8'(p);
      @(negedge clk);
      bus.round_start = collide;
      garbage_cards();
      bus.bell = bl;
      e = model_press(a1, a2, b1, b2, p, bl);
      exp_q.push_back(e);
      @(negedge clk);
      bus.round_start = 1'b0;
      check("grant", bus.grant, e.g);
      repeat (2) @(negedge clk);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("grant_held", bus.grant, (e.win != 0) ? '0 : e.g);
      end
      bus.bell = '0;
      @(negedge clk);
      check("grant_released", bus.grant, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.round_start = 1'b0;
      bus.c1 = '0; bus.c2 = '0; bus.n1 = '0; bus.n2 = '0;
      bus.pot = '0; bus.bell = '0;
      rr = 0;

      apply_reset();
      do_round(1, 1, 2, 3, 12, 2'b01, 1, 1'b0, 1'b0);
      do_round(0, 2, 4, 3, 7, 2'b10, 3, 1'b0, 1'b0);
      do_round(0, 1, 5, 0, 9, 2'b11, 0, 1'b0, 1'b0);
      do_round(2, 3, 1, 1, 9, 2'b11, 0, 1'b0, 1'b0);

      // Saturation: alternate players so nobody leads by more than the margin.
      apply_reset();
      do_round(0, 0, 2, 3, 40, 2'b10, 0, 1'b0, 1'b0);
      do_round(0, 0, 2, 3, 80, 2'b01, 0, 1'b0, 1'b0);
      do_round(0, 0, 1, 4, 40, 2'b10, 0, 1'b0, 1'b0);
      do_round(3, 3, 4, 1, 100, 2'b01, 0, 1'b0, 1'b0);

      // Margin boundary, then frozen OVER state.
      apply_reset();
      do_round(1, 1, 0, 5, 50, 2'b01, 1, 1'b1, 1'b0);
      do_round(1, 2, 5, 7, 1, 2'b01, 0, 1'b0, 1'b1);
      @(negedge clk);
      bus.round_start = 1'b1;
      garbage_cards();
      bus.bell = 2'b11;
      @(negedge clk);
      bus.round_start = 1'b0;
      repeat (4) @(negedge clk);
      check("over_grant", bus.grant, 0);
      check("over_game_over", bus.game_over, 1);
      check("over_scores", bus.scores, model_scores());
      bus.bell = '0;

      // Reset while in JUDGE: no verdict, scores stay zero.
      apply_reset();
      @(negedge clk);
      bus.round_start = 1'b1;
      bus.c1 = 2'd1; bus.c2 = 2'd1; bus.n1 = 3'd2; bus.n2 = 3'd3; bus.pot = 8'd12;
      @(negedge clk);
      bus.round_start = 1'b0;
      bus.bell = 2'b01;
      @(negedge clk);
      check("judge_grant", bus.grant, 2'b01);
      rst = 1'b0;
      bus.bell = '0;
      @(negedge clk);
      check("midrst_grant", bus.grant, 0);
      check("midrst_verdict_valid", bus.verdict_valid, 0);
      check("midrst_scores", bus.scores, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_scores_after", bus.scores, 0);

      apply_reset();
      for (int r = 0; r < 40; r++) begin
         do_round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 30), NP'($urandom_range(1, (1 << NP) - 1)), $urandom_range(0, 2),
                  1'($urandom), 1'($urandom));
         if (model_winner() != 0) apply_reset();
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
